// File: rtl/uncached_dbridge.sv
// Uncached data-side bridge: turns one uncached MMU data access at a time into a
// single-beat AXI-lite-style read or write, stalling the CPU until it completes.
module uncached_dbridge #(
  parameter logic [3:0] ID_VAL       = 4'd2,
  parameter bit         SKIP_NULL_WR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  // MMU / CPU side
  input  logic [31:0] d_addr,
  input  logic        cached_DCache,
  input  logic [1:0]  d_en,
  input  logic [2:0]  d_size,
  input  logic [3:0]  w_b_s,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        d_err,
  // read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // write address channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        req_valid;

  assign req_valid = !cached_DCache && (d_en == 2'b01 || d_en == 2'b10);

  // Request/bus sequencing with all bus-side outputs held in registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= d_addr;
            size_q  <= d_size;
            strb_q  <= w_b_s;
            wdata_q <= d_wdata;
            if (d_en == 2'b01) begin
              arvalid_q <= 1'b1;
              state_q   <= StRdA;
            end else if (SKIP_NULL_WR && w_b_s == 4'b0000) begin
              // Nothing to write: complete without touching the bus.
              state_q <= StDone;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrAw;
            end
          end
        end
        StRdA: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdD;
          end
        end
        StRdD: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= rdata;
            err_q    <= |rresp;
            state_q  <= StDone;
          end
        end
        StWrAw: begin
          // AW and W complete independently; leave once both have handshaken.
          if (awready) awvalid_q <= 1'b0;
          if (wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            bready_q <= 1'b1;
            state_q  <= StWrB;
          end
        end
        StWrB: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            err_q    <= |bresp;
            state_q  <= StDone;
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall is combinational in the accept cycle so the CPU freezes immediately.
  always_comb begin
    d_stall = (state_q == StIdle && req_valid) ||
              (state_q inside {StRdA, StRdD, StWrAw, StWrB});
  end

  assign d_rdata = rdata_q;
  assign d_err   = err_q;
  assign arid    = ID_VAL;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = ID_VAL;
  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_uncached_dbridge.sv
// Randomized scoreboard bench for uncached_dbridge with a wait-state bus slave.
module tb_uncached_dbridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] d_addr;
  logic        cached_DCache;
  logic [1:0]  d_en;
  logic [2:0]  d_size;
  logic [3:0]  w_b_s;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall, d_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  uncached_dbridge #(.ID_VAL(4'd2), .SKIP_NULL_WR(1'b1)) dut (
    .clk(clk), .resetn(resetn), .d_addr(d_addr), .cached_DCache(cached_DCache),
    .d_en(d_en), .d_size(d_size), .w_b_s(w_b_s), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall), .d_err(d_err),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int unsigned d0, d1, d2;
    logic [1:0]  resp;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  logic [31:0] model_mem[logic [29:0]];
  logic [31:0] slave_mem[logic [29:0]];
  logic [31:0] model_last;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a[31:2])) return model_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (slave_mem.exists(a[31:2])) return slave_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  // ---------------- bus slave ----------------
  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic slave_read();
    plan_t p;
    if (plan_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_ar: got arvalid=1 expected no read at %0t", $time);
      return;
    end
    p = plan_q.pop_front();
    chk("araddr", araddr, p.addr);
    chk("arsize", {29'd0, arsize}, {29'd0, p.size});
    chk("arid", {28'd0, arid}, 32'd2);
    for (int c = 0; c < 100; c++) begin
      if (c >= int'(p.d0)) arready = 1'b1;
      @(posedge clk); #2;
      if (!resetn) begin slave_idle(); return; end
      if (arready) begin arready = 1'b0; break; end
      chk("arvalid_hold", {31'd0, arvalid}, 32'd1);
      chk("araddr_stable", araddr, p.addr);
    end
    chk("rready_in_rd_d", {31'd0, rready}, 32'd1);
    for (int c = 0; c < 100; c++) begin
      if (c >= int'(p.d1)) begin
        rvalid = 1'b1; rdata = slave_rd(p.addr); rresp = p.resp;
      end
      @(posedge clk); #2;
      if (!resetn) begin slave_idle(); return; end
      if (rvalid) begin rvalid = 1'b0; rresp = 2'b00; break; end
    end
  endtask

  task automatic slave_write();
    plan_t       p;
    bit          aw_done = 0, w_done = 0;
    logic [31:0] wd;
    logic [3:0]  ws;
    if (plan_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_aw: got awvalid=%b wvalid=%b expected no write at %0t",
               awvalid, wvalid, $time);
      return;
    end
    p = plan_q.pop_front();
    chk("awaddr", awaddr, p.addr);
    chk("awsize", {29'd0, awsize}, {29'd0, p.size});
    chk("awid", {28'd0, awid}, 32'd2);
    wd = wdata; ws = wstrb;
    for (int c = 0; c < 100 && !(aw_done && w_done); c++) begin
      chk("awvalid_level", {31'd0, awvalid}, {31'd0, !aw_done});
      chk("wvalid_level", {31'd0, wvalid}, {31'd0, !w_done});
      awready = !aw_done && c >= int'(p.d0);
      wready  = !w_done && c >= int'(p.d1);
      if (wready) begin wd = wdata; ws = wstrb; end
      @(posedge clk); #2;
      if (!resetn) begin slave_idle(); return; end
      if (awready) aw_done = 1;
      if (wready) w_done = 1;
      awready = 1'b0; wready = 1'b0;
    end
    chk("wdata", wd, p.wdata);
    chk("wstrb", {28'd0, ws}, {28'd0, p.strb});
    slave_mem[p.addr[31:2]] = merge(slave_rd(p.addr), wd, ws);
    chk("valids_low_in_wr_b", {30'd0, awvalid, wvalid}, 32'd0);
    chk("bready_in_wr_b", {31'd0, bready}, 32'd1);
    for (int c = 0; c < 100; c++) begin
      if (c >= int'(p.d2)) begin bvalid = 1'b1; bresp = p.resp; end
      @(posedge clk); #2;
      if (!resetn) begin slave_idle(); return; end
      if (bvalid) begin bvalid = 1'b0; bresp = 2'b00; break; end
    end
  endtask

  initial begin
    slave_idle();
    forever begin
      @(posedge clk); #2;
      if (!resetn) plan_q.delete();
      else if (arvalid) slave_read();
      else if (awvalid || wvalid) slave_write();
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!resetn) prev = 0;
      else begin
        if (prev && !d_stall) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected: got completion expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("done_rdata", d_rdata, e.rdata);
            chk("done_err", {31'd0, d_err}, {31'd0, e.err});
          end
        end else begin
          chk("err_outside_done", {31'd0, d_err}, 32'd0);
        end
        prev = d_stall;
      end
    end
  end

  // ---------------- driver with reference model ----------------
  task automatic do_req(input logic [1:0] en, input logic cached, input logic [31:0] addr,
                        input logic [2:0] size, input logic [3:0] strb,
                        input logic [31:0] wd, input int unsigned d0, input int unsigned d1,
                        input int unsigned d2, input logic [1:0] resp);
    bit    valid = !cached && (en == 2'b01 || en == 2'b10);
    bit    is_null = 0;
    bit    done = 0;
    int    exp_stall = 0;
    int    n = 0;
    exp_t  e;
    @(posedge clk); #1;
    d_en = en; cached_DCache = cached; d_addr = addr; d_size = size; w_b_s = strb;
    d_wdata = wd;
    if (!valid) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("ignored_quiet", {28'd0, d_stall, arvalid, awvalid, wvalid}, 32'd0);
      end
      return;
    end
    if (en == 2'b01) begin
      model_last = model_rd(addr);
      e = '{rdata: model_last, err: resp != 2'b00};
      exp_stall = 3 + int'(d0) + int'(d1);
      plan_q.push_back('{1'b1, addr, size, strb, wd, d0, d1, d2, resp});
    end else if (strb == 4'b0000) begin
      is_null = 1;
      e = '{rdata: model_last, err: 1'b0};
      exp_stall = 1;
    end else begin
      model_mem[addr[31:2]] = merge(model_rd(addr), wd, strb);
      e = '{rdata: model_last, err: resp != 2'b00};
      exp_stall = 3 + int'((d0 > d1) ? d0 : d1) + int'(d2);
      plan_q.push_back('{1'b0, addr, size, strb, wd, d0, d1, d2, resp});
    end
    exp_q.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_null) chk("null_wr_quiet", {30'd0, awvalid, wvalid}, 32'd0);
      if (d_stall) n++;
      else begin done = 1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req_timeout: got no completion expected one within 200 cycles");
    end else begin
      chk("stall_cycles", n, exp_stall);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; d_en = 2'b00; cached_DCache = 1'b0; d_addr = '0; d_size = '0;
    w_b_s = '0; d_wdata = '0; model_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("reset_stall_err", {30'd0, d_stall, d_err}, 32'd0);
    chk("reset_rdata", d_rdata, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Zero-wait read of a known word.
    model_mem[30'h07F4_0001] = 32'hDEAD_BEEF;
    slave_mem[30'h07F4_0001] = 32'hDEAD_BEEF;
    do_req(2'b01, 1'b0, 32'h1FD0_0004, 3'd2, 4'h0, 32'h0, 0, 0, 0, 2'b00);
    // Byte write, AW delayed 3 cycles, W immediate; then read it back.
    do_req(2'b10, 1'b0, 32'h1FD0_000A, 3'd0, 4'b0100, 32'h00AB_0000, 3, 0, 0, 2'b00);
    do_req(2'b01, 1'b0, 32'h1FD0_0008, 3'd2, 4'h0, 32'h0, 0, 0, 0, 2'b00);
    // Cached request, and the idle encodings.
    do_req(2'b01, 1'b1, 32'h1FD0_0010, 3'd2, 4'h0, 32'h0, 0, 0, 0, 2'b00);
    do_req(2'b11, 1'b0, 32'h1FD0_0010, 3'd2, 4'hF, 32'h0, 0, 0, 0, 2'b00);
    // Null write completes without the bus.
    do_req(2'b10, 1'b0, 32'h1FD0_0014, 3'd2, 4'b0000, 32'h1234_5678, 0, 0, 0, 2'b00);
    // Error response, then a clean read.
    do_req(2'b01, 1'b0, 32'h1FD0_0018, 3'd2, 4'h0, 32'h0, 1, 2, 0, 2'b10);
    do_req(2'b01, 1'b0, 32'h1FD0_001C, 3'd2, 4'h0, 32'h0, 0, 0, 0, 2'b00);
    // Write with error response and W before AW.
    do_req(2'b10, 1'b0, 32'h1FD0_0020, 3'd2, 4'b1111, 32'hCAFE_F00D, 2, 0, 1, 2'b11);

    // Reset while waiting for read data.
    @(posedge clk); #1;
    d_en = 2'b01; cached_DCache = 1'b0; d_addr = 32'h1FD0_0024; d_size = 3'd2;
    plan_q.push_back('{1'b1, 32'h1FD0_0024, 3'd2, 4'h0, 32'h0, 0, 20, 0, 2'b00});
    begin
      bit hit = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rready) begin hit = 1; break; end
      end
      chk("reached_rd_d", {31'd0, hit}, 32'd1);
    end
    @(posedge clk); #1;
    resetn = 1'b0; d_en = 2'b00;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midreset_valids", {30'd0, arvalid, rready}, 32'd0);
    chk("midreset_stall", {31'd0, d_stall}, 32'd0);
    chk("midreset_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; model_last = '0;
    do_req(2'b01, 1'b0, 32'h1FD0_0024, 3'd2, 4'h0, 32'h0, 0, 0, 0, 2'b00);

    // Randomized traffic over a small address window.
    for (int t = 0; t < 80; t++) begin
      int unsigned k = $urandom_range(0, 9);
      logic [1:0]  en;
      logic [2:0]  sz = 3'($urandom_range(0, 2));
      logic [31:0] a = 32'h1FD0_0000 + {$urandom_range(0, 7), 2'b00};
      logic [3:0]  s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      logic [1:0]  rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (k == 0) en = 2'b00;
      else if (k == 1) en = 2'b11;
      else if (k < 6) en = 2'b01;
      else en = 2'b10;
      if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) a[1] = 1'($urandom_range(0, 1));
      do_req(en, $urandom_range(0, 7) == 0, a, sz, s, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), rsp);
    end

    @(posedge clk); #1 d_en = 2'b00;
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
